// File: rtl/bram_uart_streamer.sv
// -----------------------------------------------------------------------------
// bram_uart_streamer
//
// Purpose:
//   Reads bytes 0 .. byte_count-1 from a synchronous-read byte BRAM and sends
//   each one out on TxD as a UART frame. The default frame is 8N1: one start
//   bit, DATA_W data bits LSB first, and one stop bit. The block has its own
//   baud counter, shift register and sequencing FSM, so no separate UART
//   transmitter is needed.
//
// Optional feature:
//   TX_PARITY_EN - when this macro is defined, an even-parity bit (the XOR of
//                  the data bits) is sent in a PARITY state between the last
//                  data bit and the stop bit.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per UART bit (must be >= 2)
//   ADDR_W       - BRAM address width (depth = 2**ADDR_W)
//   DATA_W       - BRAM word width and number of data bits per frame
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   one-cycle request to stream; accepted only in IDLE
//   byte_count in   bytes to send (0 .. 2**ADDR_W; larger values are clamped)
//   rd_addr    out  BRAM read address
//   rd_data    in   BRAM read data, valid one cycle after rd_addr changes
//   busy       out  high from accepted start until the last stop bit ends
//   done       out  one-cycle pulse when the stream finishes
//   TxD        out  UART serial output, idle high
// -----------------------------------------------------------------------------
module bram_uart_streamer #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   byte_count,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              TxD
);

  localparam int LEN_W  = ADDR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(2 ** ADDR_W);
  localparam logic [LEN_W-1:0]  ONE_LEN   = LEN_W'(1);
  localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] ONE_BAUD  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  ONE_BIT   = BIT_W'(1);
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    STOP   = 3'd5,
`ifdef TX_PARITY_EN
    FINISH = 3'd6,
    PARITY = 3'd7
`else
    FINISH = 3'd6
`endif
  } state_t;

  state_t state;
  state_t state_next;

  logic [BAUD_W-1:0] baud_cnt;
  logic              baud_tick;
  logic              timed_state;
  logic [BIT_W-1:0]  bit_cnt;
  logic              last_bit;
  logic [DATA_W-1:0] shift_reg;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  sent_cnt;
  logic              last_byte;
  logic [LEN_W-1:0]  count_clamped;
  logic              start_ok;
`ifdef TX_PARITY_EN
  logic              parity_q;
`endif

  // The buffer cannot hold more than 2**ADDR_W bytes, so longer requests
  // are trimmed to a full-buffer dump instead of wrapping the address.
  assign count_clamped = (byte_count > MAX_LEN) ? MAX_LEN : byte_count;

  // done is high only while we are back in IDLE. Gating it here drops a
  // start that arrives in the same cycle as the completion pulse.
  assign start_ok = start && !done;

  assign baud_tick = (baud_cnt == LAST_BAUD);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign last_byte = ((sent_cnt + ONE_LEN) == len_q);

  // Only the bit-period states count baud cycles. The rest last one clock.
`ifdef TX_PARITY_EN
  assign timed_state = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
`else
  assign timed_state = (state == START) || (state == DATA) || (state == STOP);
`endif

  // State register. Reset drops straight to IDLE, which also forces TxD
  // high through the output decode without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Frame bits advance on baud ticks. FETCH and LOAD
  // each take one clock to cover the BRAM read latency.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = (count_clamped == '0) ? FINISH : FETCH;
        end
      end
      FETCH:  state_next = LOAD;
      LOAD:   state_next = START;
      START: begin
        if (baud_tick) state_next = DATA;
      end
      DATA: begin
        if (baud_tick && last_bit) begin
`ifdef TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (baud_tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (baud_tick) state_next = last_byte ? FINISH : FETCH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode. The line idles high everywhere outside the frame bits.
  // busy already drops in FINISH because the last stop bit has completed.
  always_comb begin
    TxD  = 1'b1;
    busy = 1'b1;
    case (state)
      IDLE:   busy = 1'b0;
      FINISH: busy = 1'b0;
      START:  TxD  = 1'b0;
      DATA:   TxD  = shift_reg[0];
`ifdef TX_PARITY_EN
      PARITY: TxD  = parity_q;
`endif
      default: begin
        TxD  = 1'b1;
        busy = 1'b1;
      end
    endcase
  end

  // Baud counter. It restarts on every state change so each bit period is
  // a clean CLKS_PER_BIT cycles. Inside DATA it wraps once per data bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
    end else if ((state_next != state) || baud_tick || !timed_state) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + ONE_BAUD;
    end
  end

  // Datapath. This block holds the length capture, the byte and address
  // sequencing, and the shift register. done is a registered copy of
  // FINISH, so the pulse lands in the first IDLE cycle after the stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      sent_cnt  <= '0;
      rd_addr   <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      done      <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start_ok) begin
            len_q    <= count_clamped;
            sent_cnt <= '0;
            rd_addr  <= '0;
          end
        end
        LOAD: begin
          shift_reg <= rd_data;
          bit_cnt   <= '0;
`ifdef TX_PARITY_EN
          parity_q  <= ^rd_data;
`endif
        end
        DATA: begin
          if (baud_tick) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + ONE_BIT;
          end
        end
        STOP: begin
          // The address moves only when another byte follows. This keeps
          // rd_addr within length-1 and stops it wrapping on a full buffer.
          if (baud_tick && !last_byte) begin
            rd_addr  <= rd_addr + ONE_ADDR;
            sent_cnt <= sent_cnt + ONE_LEN;
          end
        end
        FINISH: begin
          rd_addr <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_uart_streamer.sv
// -----------------------------------------------------------------------------
// tb_bram_uart_streamer
//
// Streams BRAM contents through bram_uart_streamer with CLKS_PER_BIT=4.
// Each accepted start pushes the expected bytes, frame start cycles and the
// done cycle into scoreboard queues. A decoder on TxD and a done monitor pop
// those queues and compare what they see against them. The decoder rebuilds
// each expected frame waveform from the UART rules and checks every clock.
// -----------------------------------------------------------------------------
module tb_bram_uart_streamer;

  localparam int CLKS  = 4;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * CLKS;
  localparam int STRIDE     = FRAME_CLKS + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   byte_count = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          TxD;

  logic [DW-1:0] mem [DEPTH];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int extra_frames = 0;
  int extra_dones = 0;
  int model_done_cyc = -1;

  logic [DW-1:0] exp_byte [$];
  int            exp_addr [$];
  int            exp_fall [$];
  int            exp_done [$];

  bram_uart_streamer #(
    .CLKS_PER_BIT(CLKS),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .byte_count(byte_count),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .TxD(TxD)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read BRAM model with one cycle of latency.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic check_output(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h), wanted %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Expected line levels for one frame, clock by clock at bit granularity.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DW-1:0] b);
    logic [FRAME_BITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[1+i] = b[i];
`ifdef TX_PARITY_EN
    f[1+DW] = ^b;
`endif
    return f;
  endfunction

  // Reference model. A start in cycle k is accepted only if no stream is
  // still in progress, counting the done cycle as in progress. An accepted
  // stream of n bytes starts frame i at k+3+i*STRIDE and pulses done at
  // k+n*STRIDE+2. byte_count is scrambled right after the start cycle.
  task automatic apply_stimulus(input int n);
    int k;
    int eff;
    k          = cyc;
    start      = 1'b1;
    byte_count = n[AW:0];
    if (k > model_done_cyc) begin
      eff = (n > DEPTH) ? DEPTH : n;
      for (int i = 0; i < eff; i++) begin
        exp_byte.push_back(mem[i]);
        exp_addr.push_back(i);
        exp_fall.push_back(k + 3 + i * STRIDE);
      end
      model_done_cyc = k + eff * STRIDE + 2;
      exp_done.push_back(model_done_cyc);
    end
    @(posedge clk); #1;
    start      = 1'b0;
    byte_count = ($urandom & 32'h1f);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_stream();
    int guard;
    guard = 0;
    while (exp_done.size() != 0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    check_output("stream_done_within_budget", exp_done.size(), 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  endtask

  // TxD decoder: detects frames, checks every clock against the expected
  // waveform, and samples each data bit in the middle of its period.
  int            rx_t;
  bit            rx_on = 1'b0;
  bit            rx_known;
  int            rx_err;
  int            rx_addr;
  logic [DW-1:0] rx_exp;
  logic [DW-1:0] rx_got;
  logic [FRAME_BITS-1:0] rx_bits;

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      rx_on = 1'b0;
    end else begin
      if (!rx_on && TxD === 1'b0) begin
        rx_on  = 1'b1;
        rx_t   = 0;
        rx_err = 0;
        rx_got = '0;
        if (exp_byte.size() == 0) begin
          extra_frames++;
          rx_known = 1'b0;
          rx_exp   = '0;
          rx_addr  = int'(rd_addr);
        end else begin
          rx_known = 1'b1;
          rx_exp   = exp_byte.pop_front();
          rx_addr  = exp_addr.pop_front();
          check_output("frame_start_cycle", cyc, exp_fall.pop_front());
          check_output("rd_addr_at_frame", rd_addr, rx_addr);
        end
        rx_bits = frame_of(rx_exp);
      end
      if (rx_on) begin
        if (TxD !== rx_bits[rx_t / CLKS]) rx_err++;
        if (int'(rd_addr) != rx_addr) rx_err++;
        if ((rx_t % CLKS) == CLKS / 2 && (rx_t / CLKS) >= 1 && (rx_t / CLKS) <= DW)
          rx_got[rx_t / CLKS - 1] = TxD;
        if (rx_t == FRAME_CLKS - 1) begin
          if (rx_known) begin
            check_output("frame_byte", rx_got, rx_exp);
            check_output("frame_waveform_errors", rx_err, 0);
          end
          rx_on = 1'b0;
        end else begin
          rx_t++;
        end
      end
    end
  end

  // done monitor: checks the pulse timing against the model and the idle
  // state that must hold in the done cycle.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (exp_done.size() == 0) begin
        extra_dones++;
      end else begin
        check_output("done_cycle", cyc, exp_done.pop_front());
        check_output("busy_at_done", busy, 0);
        check_output("rd_addr_at_done", rd_addr, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_TxD", TxD, 1);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_rd_addr", rd_addr, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single byte A5");
    mem[0] = 8'hA5;
    apply_stimulus(1);
    wait_stream();
    check_output("busy_after_single", busy, 0);

    $display("[TB] three bytes 48 69 0A");
    mem[0] = 8'h48; mem[1] = 8'h69; mem[2] = 8'h0A;
    apply_stimulus(3);
    wait_stream();

    $display("[TB] zero length");
    apply_stimulus(0);
    wait_stream();

    $display("[TB] clamp 31 to full buffer");
    fill_random();
    apply_stimulus(31);
    wait_stream();

    $display("[TB] start while busy");
    mem[0] = $urandom;
    k = cyc;
    apply_stimulus(1);
    wait_until(k + 18);
    apply_stimulus(1);
    wait_stream();

    $display("[TB] start in done cycle");
    fill_random();
    apply_stimulus(2);
    wait_until(model_done_cyc);
    apply_stimulus(2);
    repeat (60) begin
      @(posedge clk); #1;
    end
    wait_stream();

    $display("[TB] reset mid-frame");
    mem[0] = $urandom;
    k = cyc;
    apply_stimulus(1);
    wait_until(k + 21);
    reset = 1'b0;
    exp_byte.delete();
    exp_addr.delete();
    exp_fall.delete();
    exp_done.delete();
    model_done_cyc = -1;
    #1;
    check_output("midreset_TxD", TxD, 1);
    check_output("midreset_busy", busy, 0);
    check_output("midreset_done", done, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    mem[0] = $urandom;
    apply_stimulus(1);
    wait_stream();

    $display("[TB] byte 07");
    mem[0] = 8'h07;
    apply_stimulus(1);
    wait_stream();

    $display("[TB] random streams");
    for (int r = 0; r < 5; r++) begin
      fill_random();
      n = $urandom_range(1, 6);
      apply_stimulus(n);
      wait_stream();
    end

    check_output("leftover_expected_frames", exp_byte.size(), 0);
    check_output("unexpected_frames", extra_frames, 0);
    check_output("unexpected_done_pulses", extra_dones, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
